// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: next-PC select codes, reset PC and
// the branch offset helper used by the next-PC logic.
package if_stage_pkg;

  // Next-PC select codes driven by the decode controller.
  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BEQ = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard controls, decode redirect inputs, instruction
// memory port and the IF/ID register outputs.
//
// D_valid qualifies the IF/ID register: when high, D_instr/D_pc/D_pc8 hold a
// real fetched instruction; when low they hold a bubble (NOP). There is no
// ready back-pressure; the hazard unit holds the stage with stall instead.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic [1:0]  D_npc_sel;
  logic        D_cmp_eq;
  logic [31:0] D_rs_data;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] F_pc;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;
  logic        D_valid;

  // The fetch stage itself.
  modport master (
    input  stall, flush, D_npc_sel, D_cmp_eq, D_rs_data, im_rdata,
    output im_addr, F_pc, D_instr, D_pc, D_pc8, D_valid
  );

  // The surrounding pipeline / memory model.
  modport slave (
    output stall, flush, D_npc_sel, D_cmp_eq, D_rs_data, im_rdata,
    input  im_addr, F_pc, D_instr, D_pc, D_pc8, D_valid
  );
endinterface

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC selection. Branch/jump targets come from the
// instruction held in IF/ID, so a redirect lands after one delay slot.
module npc_calc
  import if_stage_pkg::*;
(
  input  logic [1:0]  npc_sel,
  input  logic        cmp_eq,
  input  logic [31:0] rs_data,
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  assign seq_pc = f_pc + 32'd4;

  // Pick the next fetch address; all arithmetic wraps modulo 2^32.
  always_comb begin
    npc = seq_pc;
    case (npc_sel_e'(npc_sel))
      NPC_SEQ: npc = seq_pc;
      NPC_BEQ: npc = cmp_eq ? (d_pc + 32'd4 + branch_offset(d_instr[15:0])) : seq_pc;
      NPC_J:   npc = {d_pc[31:28], d_instr[25:0], 2'b00};
      NPC_JR:  npc = rs_data;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, instruction memory address and the
// IF/ID pipeline register, with stall/flush control from the hazard unit.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] d_pc8_q, d_pc8_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] npc;

  npc_calc u_npc_calc (
    .npc_sel (bus.D_npc_sel),
    .cmp_eq  (bus.D_cmp_eq),
    .rs_data (bus.D_rs_data),
    .f_pc    (pc_q),
    .d_pc    (d_pc_q),
    .d_instr (d_instr_q),
    .npc     (npc)
  );

  // Flush beats stall; a flush advances the PC but leaves D_pc/D_pc8 alone.
  always_comb begin
    pc_d      = pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    d_pc8_d   = d_pc8_q;
    d_valid_d = d_valid_q;
    if (bus.flush) begin
      pc_d      = npc;
      d_instr_d = 32'd0;
      d_valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d      = npc;
      d_instr_d = bus.im_rdata;
      d_pc_d    = pc_q;
      d_pc8_d   = pc_q + 32'd8;
      d_valid_d = 1'b1;
    end
  end

  // State registers; reset overrides everything, including a pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      d_instr_q <= 32'd0;
      d_pc_q    <= PC_RESET;
      d_pc8_q   <= PC_RESET + 32'd8;
      d_valid_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
      d_pc8_q   <= d_pc8_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign bus.im_addr = pc_q;
  assign bus.F_pc    = pc_q;
  assign bus.D_instr = d_instr_q;
  assign bus.D_pc    = d_pc_q;
  assign bus.D_pc8   = d_pc8_q;
  assign bus.D_valid = d_valid_q;

endmodule
